// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input, decode handshake,
// run enable and the sticky misalignment flag.
interface fetch_if;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        misalign_err;

   // Controller side
   modport master (
      input  fetch_en,
      output imem_addr,
      input  imem_inst,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      output out_inst,
      output out_pc,
      input  out_ready,
      output misalign_err
   );

   // Environment side: memory, branch unit and decode
   modport slave (
      output fetch_en,
      input  imem_addr,
      output imem_inst,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      input  out_inst,
      input  out_pc,
      output out_ready,
      input  misalign_err
   );
endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: owns the fetch PC, drives the combinational instruction
// memory and queues {instruction, pc} pairs in a small FIFO for decode.
// Redirects flush the FIFO; misaligned redirect targets park the unit in ERR.
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 1024,
   parameter int          DEPTH     = 2
) (
   input logic    clk,
   input logic    rst_n,
   fetch_if.master bus
);

   localparam int              PTR_W     = $clog2(DEPTH);
   localparam int              CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [31:0]     ADDR_MASK = 32'(MEM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t           state_reg, state_next;
   logic [31:0]      fetch_pc_reg, fetch_pc_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             misalign_reg, misalign_next;
   logic [31:0]      inst_mem_reg [DEPTH];
   logic [31:0]      pc_mem_reg   [DEPTH];

   logic pop;
   logic push;
   logic redirect_ok;

   assign redirect_ok = (bus.redirect_pc[1:0] == 2'b00);
   assign pop         = (count_reg != '0) & bus.out_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push        = (state_reg == RUN) & bus.fetch_en & ~bus.redirect_valid
                        & ((count_reg < DEPTH_C) | pop);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next state: redirects take priority over the run-enable transitions
   always_comb begin
      state_next = state_reg;
      if (bus.redirect_valid) begin
         if (!redirect_ok)      state_next = ERR;
         else if (bus.fetch_en) state_next = RUN;
         else                   state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (bus.fetch_en)  state_next = RUN;
            RUN:     if (!bus.fetch_en) state_next = IDLE;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
         endcase
      end
   end

   // Next PC, FIFO bookkeeping and sticky error
   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      count_next    = count_reg;
      misalign_next = misalign_reg;
      if (bus.redirect_valid) begin
         // A same-cycle pop is already consumed; everything else is dropped.
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
         if (redirect_ok) fetch_pc_next = bus.redirect_pc & ADDR_MASK;
         else             misalign_next = 1'b1;
      end else begin
         if (push) begin
            fetch_pc_next = (fetch_pc_reg + 32'd4) & ADDR_MASK;
            wr_ptr_next   = wr_ptr_reg + 1'b1;
         end
         if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg <= RESET_PC;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         misalign_reg <= 1'b0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
         misalign_reg <= misalign_next;
      end
   end

   // FIFO storage, one slot per entry; cleared on reset so the head reads 0
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Capture the memory word and its PC when this slot is the tail
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            inst_mem_reg[gi] <= '0;
            pc_mem_reg[gi]   <= '0;
         end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
            inst_mem_reg[gi] <= bus.imem_inst;
            pc_mem_reg[gi]   <= fetch_pc_reg;
         end
      end
   end

   assign bus.imem_addr    = fetch_pc_reg;
   assign bus.out_valid    = (count_reg != '0);
   assign bus.out_inst     = inst_mem_reg[rd_ptr_reg];
   assign bus.out_pc       = pc_mem_reg[rd_ptr_reg];
   assign bus.misalign_err = misalign_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, backpressure, redirect,
// address wrap, misaligned redirect and asynchronous reset.
module tb_fetch_controller;

   logic clk;
   logic rst_n;
   int   vec_count;
   int   err_count;

   fetch_if bus ();

   fetch_controller #(
      .RESET_PC (32'h0000_0000),
      .MEM_BYTES(1024),
      .DEPTH    (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: word index i holds (i+1)*0x11111111
   function automatic logic [31:0] word_at(input logic [31:0] addr);
      logic [31:0] idx;
      idx = (addr >> 2) + 32'd1;
      return idx * 32'h1111_1111;
   endfunction

   assign bus.imem_inst = word_at(bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n              = 1'b0;
      bus.fetch_en       = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      step();
      step();
      vec_count++;
      if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0 ||
          bus.misalign_err !== 1'b0 || bus.imem_addr !== 32'h0) begin
         err_count++;
         $display("FAIL reset: valid=%b inst=%h pc=%h err=%b addr=%h, expected all zero",
                  bus.out_valid, bus.out_inst, bus.out_pc, bus.misalign_err, bus.imem_addr);
      end
      rst_n = 1'b1;
      $display("reset: checked reset state");
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      bus.fetch_en  = 1'b1;
      bus.out_ready = 1'b1;
      step();  // IDLE -> RUN, nothing fetched yet
      vec_count++;
      if (bus.out_valid !== 1'b0) begin
         err_count++;
         $display("FAIL stream_start: out_valid=%b expected 0", bus.out_valid);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         exp_pc = 32'(4 * k);
         vec_count++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word_at(exp_pc)) begin
            err_count++;
            $display("FAIL stream_%0d: valid=%b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                     k, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, word_at(exp_pc));
         end
         $display("stream: pc=%h inst=%h", bus.out_pc, bus.out_inst);
      end
   endtask

   // Head 0x14 valid, fetch_pc 0x18 on entry
   task automatic test_backpressure();
      logic [31:0] exp_pc;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         vec_count++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h14 || bus.out_inst !== 32'h6666_6666 ||
             bus.imem_addr !== 32'h1C) begin
            err_count++;
            $display("FAIL stall_%0d: valid=%b pc=%h inst=%h addr=%h expected 1 00000014 66666666 0000001c",
                     k, bus.out_valid, bus.out_pc, bus.out_inst, bus.imem_addr);
         end
         $display("stall: pc=%h addr=%h", bus.out_pc, bus.imem_addr);
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         exp_pc = 32'h18 + 32'(4 * k);
         vec_count++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word_at(exp_pc)) begin
            err_count++;
            $display("FAIL release_%0d: valid=%b pc=%h inst=%h expected valid=1 pc=%h",
                     k, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc);
         end
         $display("release: pc=%h", bus.out_pc);
      end
   endtask

   // FIFO full (0x20, 0x24) on entry
   task automatic test_redirect();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      step();
      bus.redirect_valid = 1'b0;
      vec_count++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
         err_count++;
         $display("FAIL redirect_flush: valid=%b addr=%h expected 0 00000040",
                  bus.out_valid, bus.imem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         vec_count++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 + 32'(4 * k)) begin
            err_count++;
            $display("FAIL redirect_%0d: valid=%b pc=%h expected 1 %h",
                     k, bus.out_valid, bus.out_pc, 32'h40 + 32'(4 * k));
         end
         $display("redirect: pc=%h", bus.out_pc);
      end
   endtask

   task automatic test_wrap();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h3F8;
      step();
      bus.redirect_valid = 1'b0;
      step();
      vec_count++;
      if (bus.out_pc !== 32'h3F8 || bus.out_valid !== 1'b1) begin
         err_count++;
         $display("FAIL wrap_a: valid=%b pc=%h expected 1 000003f8", bus.out_valid, bus.out_pc);
      end
      step();
      vec_count++;
      if (bus.out_pc !== 32'h3FC || bus.imem_addr !== 32'h0) begin
         err_count++;
         $display("FAIL wrap_b: pc=%h addr=%h expected 000003fc 00000000", bus.out_pc, bus.imem_addr);
      end
      step();
      vec_count++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h1111_1111) begin
         err_count++;
         $display("FAIL wrap_c: valid=%b pc=%h inst=%h expected 1 00000000 11111111",
                  bus.out_valid, bus.out_pc, bus.out_inst);
      end
      $display("wrap: pc=%h after 000003fc", bus.out_pc);
   endtask

   // fetch_pc 0x4 on entry
   task automatic test_misalign();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h42;
      step();
      bus.redirect_valid = 1'b0;
      vec_count++;
      if (bus.misalign_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin
         err_count++;
         $display("FAIL misalign: err=%b valid=%b addr=%h expected 1 0 00000004",
                  bus.misalign_err, bus.out_valid, bus.imem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         vec_count++;
         if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin
            err_count++;
            $display("FAIL err_hold_%0d: valid=%b addr=%h expected 0 00000004",
                     k, bus.out_valid, bus.imem_addr);
         end
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h80;
      step();
      bus.redirect_valid = 1'b0;
      step();
      vec_count++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80 || bus.out_inst !== word_at(32'h80) ||
          bus.misalign_err !== 1'b1) begin
         err_count++;
         $display("FAIL resume: valid=%b pc=%h inst=%h err=%b expected 1 00000080 %h 1",
                  bus.out_valid, bus.out_pc, bus.out_inst, bus.misalign_err, word_at(32'h80));
      end
      step();
      vec_count++;
      if (bus.out_pc !== 32'h84) begin
         err_count++;
         $display("FAIL resume_next: pc=%h expected 00000084", bus.out_pc);
      end
      $display("misalign: err=%b resumed pc=%h", bus.misalign_err, bus.out_pc);
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;  // still before the next rising edge
      vec_count++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0 ||
          bus.misalign_err !== 1'b0 || bus.imem_addr !== 32'h0) begin
         err_count++;
         $display("FAIL async_reset: valid=%b pc=%h inst=%h err=%b addr=%h expected all zero",
                  bus.out_valid, bus.out_pc, bus.out_inst, bus.misalign_err, bus.imem_addr);
      end
      step();
      rst_n = 1'b1;
      step();  // IDLE -> RUN
      step();
      vec_count++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h1111_1111) begin
         err_count++;
         $display("FAIL restart: valid=%b pc=%h inst=%h expected 1 00000000 11111111",
                  bus.out_valid, bus.out_pc, bus.out_inst);
      end
      $display("async_reset: restart pc=%h", bus.out_pc);
   endtask

   initial begin
      vec_count = 0;
      err_count = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_misalign();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
